mdu_divider: RTL
================

// Module: mdu_divider
// PURPOSE
//  Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) in the execute stage.
//  Consumes the two operands read from register_bank (read_data_1/read_data_2).
//  Returns the 32-bit result and destination address, plus a write enable for the writeback port.
//  Restoring division, one quotient bit per clock; fixed latency so the hazard stall is deterministic.
// PARAMETERS
//  XLEN      32  operand/result width; counter width = $clog2(XLEN)+1
//  ADDR_W     5  register address width (matches register_bank)
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  start         in   1       request; sampled only in IDLE
//  flush         in   1       abort in-flight op (pipeline flush)
//  op            in   2       div_op_t: DIV=0, DIVU=1, REM=2, REMU=3
//  operand_a     in   XLEN    dividend (rs1 data)
//  operand_b     in   XLEN    divisor (rs2 data)
//  rd_addr_in    in   ADDR_W  destination register
//  busy          out  1       1 from cycle after start accepted until done cycle inclusive
//  done          out  1       single-cycle pulse, result valid
//  write_enable  out  1       == done && rd_addr_out != 0
//  rd_addr_out   out  ADDR_W  latched rd_addr_in
//  result        out  XLEN    quotient or remainder; held until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, write_enable=0, rd_addr_out=0, result=0; all internals cleared.
//  FSM IDLE -> CALC -> FINISH -> IDLE.
//  IDLE: start=1 & flush=0 -> latch op and rd_addr_in; capture |a|, |b| (signed ops only); capture sign flags; count=0.
//    Then go to CALC. start with flush=1 is ignored.
//  CALC: one restoring step per cycle. {rem,quo} shifted left 1 bit; trial = rem - divisor; if non-negative, rem=trial and quo[0]=1.
//    count++. After XLEN steps -> FINISH.
//  FINISH: done=1 for exactly one cycle. result=(op is DIV/DIVU) ? quotient : remainder, sign-corrected:
//    quotient negated when sign(a)!=sign(b) (signed ops only).
//    remainder takes the sign of the dividend.
//    Next state IDLE. A start in FINISH is not accepted; it must be re-presented in IDLE.
//  Latency: start sampled at edge N -> done high during cycle N+XLEN+1 (33 for XLEN=32).
//  Special cases: same latency, result overridden in FINISH:
//    divisor=0: quotient=all ones (both signed and unsigned), remainder=operand_a.
//    DIV/REM with a=0x80000000, b=0xFFFFFFFF: quotient=0x80000000, remainder=0.
//  start while busy: ignored; operands/op/rd are not re-latched.
//  flush in CALC or FINISH: next state IDLE. done/write_enable are forced low in that same cycle.
//    result keeps its previous value.
//  Reset mid-operation: immediate return to reset values; no done.
//  rd_addr_out=0: done still pulses; write_enable stays 0 (x0 is never written).
//  All arithmetic unsigned on XLEN+1-bit partial remainder; no X propagation from unused operands.
// STRUCTURE
//  riscv_pkg: XLEN, div_op_t enum.
//  riscv_pkg also holds DIV_BY_ZERO_Q = '1 and INT_MIN = {1'b1,{XLEN-1{1'b0}}}.
//  Sub-module div_step: combinational single restoring step (rem_in, quo_in, divisor -> rem_out, quo_out).
//  Top: FSM, counter, sign pre/post-processing, special-case override.
// TESTING
//  DIVU a=100 b=7 rd=5 -> done 33 cycles after start; result=14; rd_addr_out=5; write_enable=1.
//  REM a=-7 (0xFFFFFFF9) b=2 -> result=0xFFFFFFFF (-1).
//  DIV a=-7 b=2 -> result=0xFFFFFFFD (-3).
//  DIV a=5 b=0 -> 0xFFFFFFFF.
//  REMU a=5 b=0 -> 5.
//  DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000.
//  REM with the same operands -> 0.
//  start re-pulsed at cycle 10 of an op -> ignored, single done at cycle 33.
//  flush at cycle 20 -> no done; next start accepted in IDLE.
//  rd=0 -> done=1, write_enable=0.
//  rst_n low at cycle 15 -> outputs reset same cycle.
//  After reset release, DIVU 0xFFFFFFFF/1 -> result=0xFFFFFFFF.
//  Random 1000 ops vs. reference model: result, latency and write_enable all match.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M divider definitions: datapath widths, operation encoding and
// the architecturally defined special-case results.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
  localparam logic [XLEN-1:0] INT_MIN       = {1'b1, {XLEN-1{1'b0}}};

  function automatic logic is_signed_op(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_div_op(input div_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, subtract the divisor,
// and keep the difference only when it does not go negative.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] rem_shift;
  logic [XLEN:0] trial;

  // The partial remainder stays below the divisor, so the shifted value needs
  // only one extra bit and trial[XLEN] acts as the borrow/sign flag.
  always_comb begin
    rem_shift = {rem_in, quo_in[XLEN-1]};
    trial     = rem_shift - {1'b0, divisor};
    if (!trial[XLEN]) begin
      rem_out = trial[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = rem_shift[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit with fixed latency: operands are made
// unsigned on entry, XLEN restoring steps run, then sign and special cases fix up.
module mdu_divider
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   operand_a,
  input  logic [XLEN-1:0]   operand_b,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic              busy,
  output logic              done,
  output logic              write_enable,
  output logic [ADDR_W-1:0] rd_addr_out,
  output logic [XLEN-1:0]   result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  state_t              state_q, state_d;
  div_op_t             op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]     divisor_q, divisor_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                div_zero_q, div_zero_d;
  logic                ovf_q, ovf_d;

  div_op_t             op_in;
  logic                a_neg, b_neg;
  logic [XLEN-1:0]     step_rem, step_quo;
  logic [XLEN-1:0]     quo_fix, rem_fix, final_res;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  assign op_in = div_op_t'(op);
  assign a_neg = is_signed_op(op_in) & operand_a[XLEN-1];
  assign b_neg = is_signed_op(op_in) & operand_b[XLEN-1];

  // Remainder follows the dividend sign; with a zero divisor the magnitude is |a|,
  // so the restored sign reproduces operand_a exactly.
  always_comb begin
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
    if (div_zero_q) begin
      quo_fix = DIV_BY_ZERO_Q;
    end else if (ovf_q) begin
      quo_fix = INT_MIN;
      rem_fix = '0;
    end
    final_res = is_div_op(op_q) ? quo_fix : rem_fix;
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    result_d   = result_q;
    count_d    = count_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d       = op_in;
          rd_d       = rd_addr_in;
          quo_d      = a_neg ? -operand_a : operand_a;
          divisor_d  = b_neg ? -operand_b : operand_b;
          rem_d      = '0;
          count_d    = '0;
          neg_quo_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = (operand_b == '0);
          ovf_d      = is_signed_op(op_in) && (operand_a == INT_MIN) && (operand_b == '1);
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + 1'b1;
          if (count_q == LAST_STEP) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        if (!flush) result_d = final_res;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= DIV;
      rd_q       <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      result_q   <= '0;
      count_q    <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      result_q   <= result_d;
      count_q    <= count_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
    end
  end

  // The result is shown live during the done cycle, then held from result_q.
  assign done         = (state_q == S_FINISH) && !flush;
  assign busy         = (state_q != S_IDLE);
  assign write_enable = done && (rd_q != '0);
  assign rd_addr_out  = rd_q;
  assign result       = done ? final_res : result_q;

endmodule
